// File: rtl/count_sample_pkg.sv
// Shared definitions for the counter-bank sampling FIFO.
// A sample is the bank's data word tagged with its overflow flag.
package count_sample_pkg;

  localparam int SAMPLE_DW = 8;

  typedef struct packed {
    logic                 ovf;
    logic [SAMPLE_DW-1:0] data;
  } sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count, full/empty flags and a
// combinational head read. A push and a pop on the same edge are both accepted.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is only allowed when a pop frees the slot on the same edge
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (level == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/count_sample_fifo.sv
// Samples the counter bank every DIV cycles into a FIFO drained over a
// valid/ready stream, with saturating drop and overflow statistics.
module count_sample_fifo
  import count_sample_pkg::*;
#(
  parameter int DW    = SAMPLE_DW,
  parameter int DEPTH = 4,
  parameter int DIV   = 4,
  parameter int CW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_en,
  input  logic [DW-1:0]          data_in,
  input  logic                   ovf_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DW:0]            m_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CW-1:0]          drop_cnt,
  output logic [CW-1:0]          ovf_cnt
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DCW-1:0] div_cnt;
  logic           tick;
  logic           push;
  logic           pop;
  logic           drop;
  logic           full;
  logic           empty;
  logic [DW:0]    head;

  assign tick = sample_en & (div_cnt == DCW'(DIV-1));

  // Disabling sampling restarts the interval so re-enable waits a full DIV cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          div_cnt <= '0;
    else if (!sample_en) div_cnt <= '0;
    else if (tick)       div_cnt <= '0;
    else                 div_cnt <= div_cnt + 1'b1;
  end

  assign pop  = m_valid & m_ready;
  assign push = tick & (~full | pop);
  assign drop = tick & ~push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (drop && (drop_cnt != {CW{1'b1}}))          drop_cnt <= drop_cnt + 1'b1;
      if (tick && ovf_in && (ovf_cnt != {CW{1'b1}})) ovf_cnt  <= ovf_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DW+1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({ovf_in, data_in}),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Slots past the head hold stale data, so the stream reads zero when idle
  assign m_valid = ~empty;
  assign m_data  = m_valid ? head : '0;

endmodule
